// File: rtl/neopix_pkg.sv
// WS2812 shared definitions: bus timing defaults, pixel word width, FSM state
// encoding and the ns/us to clock-cycle conversion used by both rx and tx.
// Latency: n/a (constants and pure functions). Backpressure: n/a.
package neopix_pkg;

  // Nominal WS2812 waveform
  localparam int WS_T0H_NS       = 350;
  localparam int WS_T1H_NS       = 700;
  localparam int WS_BIT_NS       = 1250;
  localparam int WS_THRESHOLD_NS = 600;
  localparam int WS_MIN_HIGH_NS  = 100;
  localparam int WS_RESET_US     = 50;

  // One pixel word: {G[7:0], R[7:0], B[7:0]}, G7 on the wire first
  localparam int PIXEL_W = 24;

  typedef enum logic [2:0] {
    ST_WAIT_GAP,
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } rx_state_t;

  // Integer, truncating conversions from wall time to clock cycles
  function automatic int ns_to_cycles(input int clk_hz, input int ns);
    return (clk_hz / 1_000_000) * ns / 1000;
  endfunction

  function automatic int us_to_cycles(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/neopix_rx_sync_edge.sv
// Two-flop synchronizer for an asynchronous line plus registered rise/fall
// strobes. Latency: 3 clk_i edges from pin to lvl_o/rise_o/fall_o. No backpressure.
//
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   din_i          : asynchronous input
//   lvl_o          : synchronized and delayed level, aligned with the strobes
//   rise_o, fall_o : 1-cycle strobes on a 0->1 / 1->0 transition of lvl_o
module sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic din_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta;
  logic sync;

  // lvl_o doubles as the delay flop: the strobes compare the freshly
  // synchronized value against it before it is overwritten, so after each edge
  // lvl_o already shows the new level in the same cycle the strobe is high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      lvl_o  <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      meta   <= din_i;
      sync   <= meta;
      lvl_o  <= sync;
      rise_o <= sync & ~lvl_o;
      fall_o <= ~sync & lvl_o;
    end
  end

endmodule

// File: rtl/neopix_rx.sv
// WS2812 single-wire receiver: classifies high pulses into bits, packs 24-bit GRB words.
// Latency: pixel_vld_o 4 clk_i edges after the closing fall; frame_done_o RST+4 after the last fall.
// Backpressure: none; strobes cannot be stalled, pixels past NUM_LEDS are dropped and flagged.
//
// Ports:
//   clk_i, reset_i : system clock, synchronous active-high reset
//   din_i          : asynchronous NeoPixel data line
//   pixel_o        : last completed word {G,R,B}, bit 23 first on the wire
//   pixel_vld_o    : 1-cycle strobe, pixel_o / pixel_idx_o valid
//   pixel_idx_o    : 0-based index of the pixel in the frame
//   frame_done_o   : 1-cycle strobe on a latch gap that ends a frame
//   err_o          : 1-cycle strobe on a glitch or a partial pixel at latch
//   overflow_o     : sticky, frame carried more than NUM_LEDS pixels
//   rx_bsy_o       : frame in progress (HIGH/LOW states)
module neopix_rx
  import neopix_pkg::*;
#(
  parameter int SYSTEM_CLOCK     = 100_000_000,
  parameter int NUM_LEDS         = 256,
  parameter int BIT_THRESHOLD_NS = WS_THRESHOLD_NS,
  parameter int MIN_HIGH_NS      = WS_MIN_HIGH_NS,
  parameter int RESET_US         = WS_RESET_US
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        din_i,
  output logic [PIXEL_W-1:0]          pixel_o,
  output logic                        pixel_vld_o,
  output logic [$clog2(NUM_LEDS)-1:0] pixel_idx_o,
  output logic                        frame_done_o,
  output logic                        err_o,
  output logic                        overflow_o,
  output logic                        rx_bsy_o
);

  localparam int THR  = ns_to_cycles(SYSTEM_CLOCK, BIT_THRESHOLD_NS);
  localparam int MINH = ns_to_cycles(SYSTEM_CLOCK, MIN_HIGH_NS);
  localparam int RST  = us_to_cycles(SYSTEM_CLOCK, RESET_US);

  localparam int CW = $clog2(RST + 1);       // duration counter, holds RST
  localparam int IW = $clog2(NUM_LEDS);      // reported index width
  localparam int XW = $clog2(NUM_LEDS + 1);  // internal index, must reach NUM_LEDS

  localparam logic [CW-1:0] THR_C  = CW'(THR);
  localparam logic [CW-1:0] MINH_C = CW'(MINH);
  localparam logic [CW-1:0] RST_C  = CW'(RST);
  localparam logic [XW-1:0] NUM_C  = XW'(NUM_LEDS);
  localparam logic [4:0]    LAST_BIT = 5'(PIXEL_W - 1);

  logic            lvl;
  logic            rise;
  logic            fall;

  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic            bit_val;
  logic [4:0]      bit_cnt;
  logic [PIXEL_W-2:0] word;   // first 23 bits; the 24th goes straight to pixel_o
  logic [XW-1:0]   idx;

  sync_edge u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .din_i   (din_i),
    .lvl_o   (lvl),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // The counter saturates at RST so an overlong high simply reads as a 1 and an
  // overlong low is a single latch, never a wrap back into small counts.
  always_comb begin
    cnt_inc = (cnt == RST_C) ? cnt : cnt + 1'b1;
    bit_val = (cnt >= THR_C);
  end

  // Counting convention: the counter is loaded with 1 on the strobe that opens
  // a level, so on the closing strobe it equals the number of cycles that level
  // was seen. This makes THR/MINH/RST compare directly against cycle counts.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= ST_WAIT_GAP;
      cnt          <= '0;
      bit_cnt      <= '0;
      word         <= '0;
      idx          <= '0;
      pixel_o      <= '0;
      pixel_vld_o  <= 1'b0;
      pixel_idx_o  <= '0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
      overflow_o   <= 1'b0;
      rx_bsy_o     <= 1'b0;
    end else begin
      pixel_vld_o  <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;

      case (state)
        // Resynchronise to the stream: only a full latch-length low proves we
        // are between frames, any high restarts the wait.
        ST_WAIT_GAP: begin
          rx_bsy_o <= 1'b0;
          if (lvl) begin
            cnt <= '0;
          end else if (cnt_inc == RST_C) begin
            cnt   <= '0;
            idx   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_IDLE: begin
          if (rise) begin
            cnt        <= CW'(1);
            overflow_o <= 1'b0;
            rx_bsy_o   <= 1'b1;
            state      <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            if (cnt < MINH_C) begin
              // Runt pulse: the bit alignment is lost, drop the partial word.
              err_o    <= 1'b1;
              bit_cnt  <= '0;
              word     <= '0;
              cnt      <= '0;
              rx_bsy_o <= 1'b0;
              state    <= ST_WAIT_GAP;
            end else begin
              cnt   <= CW'(1);
              state <= ST_LOW;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                if (idx < NUM_C) begin
                  pixel_o     <= {word, bit_val};
                  pixel_vld_o <= 1'b1;
                  pixel_idx_o <= idx[IW-1:0];
                  idx         <= idx + 1'b1;
                end else begin
                  overflow_o <= 1'b1;
                end
              end else begin
                word    <= {word[PIXEL_W-3:0], bit_val};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_LOW: begin
          if (rise) begin
            cnt   <= CW'(1);
            state <= ST_HIGH;
          end else if (cnt_inc == RST_C) begin
            cnt      <= cnt_inc;
            rx_bsy_o <= 1'b0;
            state    <= ST_LATCH;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_LATCH: begin
          frame_done_o <= 1'b1;
          if (bit_cnt != '0) begin
            err_o <= 1'b1;
          end
          bit_cnt <= '0;
          word    <= '0;
          idx     <= '0;
          // A new frame starting in this very cycle must not be lost.
          if (rise) begin
            cnt        <= CW'(1);
            overflow_o <= 1'b0;
            rx_bsy_o   <= 1'b1;
            state      <= ST_HIGH;
          end else begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= ST_WAIT_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopix_rx.sv
`timescale 1ns/1ps
module tb_neopix_rx;
  // Latch gap shortened to 10 us (1000 cycles) to keep the run short.
  localparam int RST_CYC = 1000;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        din_i;

  logic [23:0] pixel_o;
  logic        pixel_vld_o;
  logic [7:0]  pixel_idx_o;
  logic        frame_done_o, err_o, overflow_o, rx_bsy_o;

  logic [23:0] pixel4;
  logic        pixel_vld4;
  logic [1:0]  pixel_idx4;
  logic        frame_done4, err4, overflow4, rx_bsy4;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  neopix_rx #(.SYSTEM_CLOCK(100_000_000), .NUM_LEDS(256), .BIT_THRESHOLD_NS(600),
              .MIN_HIGH_NS(100), .RESET_US(10)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .din_i(din_i),
    .pixel_o(pixel_o), .pixel_vld_o(pixel_vld_o), .pixel_idx_o(pixel_idx_o),
    .frame_done_o(frame_done_o), .err_o(err_o), .overflow_o(overflow_o),
    .rx_bsy_o(rx_bsy_o));

  neopix_rx #(.SYSTEM_CLOCK(100_000_000), .NUM_LEDS(4), .BIT_THRESHOLD_NS(600),
              .MIN_HIGH_NS(100), .RESET_US(10)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .din_i(din_i),
    .pixel_o(pixel4), .pixel_vld_o(pixel_vld4), .pixel_idx_o(pixel_idx4),
    .frame_done_o(frame_done4), .err_o(err4), .overflow_o(overflow4),
    .rx_bsy_o(rx_bsy4));

  // Strobe recorder, sampled on the falling edge
  logic [31:0] pix_q[$];
  logic [31:0] pix4_q[$];
  int fd_cnt = 0, err_cnt = 0, both_cnt = 0, fd4_cnt = 0, diverge = 0;

  always @(negedge clk_i) begin
    if (pixel_vld_o) pix_q.push_back({pixel_idx_o, pixel_o});
    if (pixel_vld4)  pix4_q.push_back({6'd0, pixel_idx4, pixel4});
    if (frame_done_o) fd_cnt++;
    if (err_o) err_cnt++;
    if (frame_done_o && err_o) both_cnt++;
    if (frame_done4) fd4_cnt++;
    if (rx_bsy4 !== rx_bsy_o || err4 !== err_o || frame_done4 !== frame_done_o) diverge++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_pulse(input int th_ns);
    din_i = 1'b1;
    #(th_ns);
    din_i = 1'b0;
    #(1250 - th_ns);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_pulse(w[i] ? 700 : 350);
  endtask

  task automatic send_pixel(input logic [23:0] w);
    send_bits(w, 24);
  endtask

  task automatic gap_us(input int us);
    din_i = 1'b0;
    #(us * 1000);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bq, bq4, bfd, berr, bboth, bfd4, n;

    // ---- reset state
    reset_i = 1'b1;
    din_i   = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_vld",  pixel_vld_o, 0);
    chk("rst_pix",  pixel_o, 0);
    chk("rst_idx",  pixel_idx_o, 0);
    chk("rst_fd",   frame_done_o, 0);
    chk("rst_err",  err_o, 0);
    chk("rst_ovf",  overflow_o, 0);
    chk("rst_bsy",  rx_bsy_o, 0);
    reset_i = 1'b0;
    #1;                     // stimulus edges sit 2 ns after a rising clk edge
    gap_us(12);

    // ---- three pixels, exact decode latency and latch timing
    bq = pix_q.size(); bfd = fd_cnt; berr = err_cnt;
    send_pixel(24'hFF0000);
    send_pixel(24'h00AA55);
    send_bits(24'h000001, 23);
    din_i = 1'b1; #700; din_i = 1'b0;   // bit 23 of pixel 2
    repeat (3) @(posedge clk_i);
    #1;
    chk("lat_edge3_vld", pixel_vld_o, 0);
    @(posedge clk_i);
    #1;
    chk("lat_edge4_vld", pixel_vld_o, 1);
    chk("lat_edge4_pix", pixel_o, 24'h000001);
    chk("lat_edge4_idx", pixel_idx_o, 2);
    chk("bsy_in_frame", rx_bsy_o, 1);
    n = 4;
    while (frame_done_o !== 1'b1 && n < 3000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("fd_latency", n, RST_CYC + 4);
    chk("bsy_after_latch", rx_bsy_o, 0);
    #1; #8000;
    chk("t1_npix", pix_q.size() - bq, 3);
    if (pix_q.size() >= bq + 3) begin
      chk("t1_pix0", pix_q[bq],     32'h00FF0000);
      chk("t1_pix1", pix_q[bq + 1], 32'h0100AA55);
      chk("t1_pix2", pix_q[bq + 2], 32'h02000001);
    end
    chk("t1_fd", fd_cnt - bfd, 1);
    chk("t1_err", err_cnt - berr, 0);

    // ---- threshold sweep: 590 ns -> 0, 610 ns -> 1, 100 ns -> 0 (not a glitch)
    bq = pix_q.size(); bfd = fd_cnt; berr = err_cnt;
    for (int i = 23; i >= 0; i--) begin
      if (i == 0) send_pulse(100);
      else send_pulse((i % 2 == 0) ? 610 : 590);
    end
    gap_us(12);
    chk("sweep_npix", pix_q.size() - bq, 1);
    if (pix_q.size() > bq) chk("sweep_pix", pix_q[bq], 32'h00555554);
    chk("sweep_err", err_cnt - berr, 0);
    chk("sweep_fd", fd_cnt - bfd, 1);

    // ---- 80 ns glitch, then resync only after a full gap
    bq = pix_q.size(); bfd = fd_cnt; berr = err_cnt;
    send_bits(24'hA00000, 3);
    send_pulse(80);
    chk("glitch_err", err_cnt - berr, 1);
    chk("glitch_bsy", rx_bsy_o, 0);
    send_pixel(24'hABCDEF);
    gap_us(12);
    chk("glitch_drop_npix", pix_q.size() - bq, 0);
    chk("glitch_no_fd", fd_cnt - bfd, 0);
    send_pixel(24'h0F0F0F);
    gap_us(12);
    chk("glitch_resync_npix", pix_q.size() - bq, 1);
    if (pix_q.size() > bq) chk("glitch_resync_pix", pix_q[bq], 32'h000F0F0F);
    chk("glitch_total_err", err_cnt - berr, 1);

    // ---- partial pixel at latch
    bq = pix_q.size(); bfd = fd_cnt; berr = err_cnt; bboth = both_cnt;
    send_bits(24'hFFF000, 12);
    gap_us(12);
    chk("partial_both", both_cnt - bboth, 1);
    chk("partial_npix", pix_q.size() - bq, 0);
    send_pixel(24'h00FF00);
    gap_us(12);
    chk("partial_next_npix", pix_q.size() - bq, 1);
    if (pix_q.size() > bq) chk("partial_next_pix", pix_q[bq], 32'h0000FF00);
    chk("partial_err_total", err_cnt - berr, 1);

    // ---- overflow on the 4-pixel instance
    bq = pix_q.size(); bq4 = pix4_q.size(); bfd4 = fd4_cnt;
    for (int k = 0; k < 6; k++) begin
      send_pixel(24'h111111 * (k + 1));
      if (k == 3) chk("ovf_after4", overflow4, 0);
      if (k == 4) chk("ovf_after5", overflow4, 1);
    end
    gap_us(12);
    chk("ovf_n4", pix4_q.size() - bq4, 4);
    if (pix4_q.size() >= bq4 + 4) begin
      chk("ovf_first4", pix4_q[bq4],     32'h00111111);
      chk("ovf_last4",  pix4_q[bq4 + 3], 32'h03444444);
    end
    chk("ovf_sticky", overflow4, 1);
    chk("ovf_fd4", fd4_cnt - bfd4, 1);
    chk("ovf_big_n", pix_q.size() - bq, 6);
    if (pix_q.size() >= bq + 6) chk("ovf_big_last", pix_q[bq + 5], 32'h05666666);
    chk("ovf_big_flag", overflow_o, 0);
    din_i = 1'b1; #350; din_i = 1'b0;
    chk("ovf_cleared", overflow4, 0);
    #900;
    gap_us(12);

    // ---- reset mid-frame
    bq = pix_q.size(); bfd = fd_cnt;
    send_bits(24'hFFFFFF, 10);
    reset_i = 1'b1;
    #30;
    chk("midrst_bsy", rx_bsy_o, 0);
    reset_i = 1'b0;
    send_pixel(24'hFFFFFF);
    #200;
    chk("midrst_npix", pix_q.size() - bq, 0);
    gap_us(12);
    chk("midrst_fd", fd_cnt - bfd, 0);
    send_pixel(24'h123456);
    gap_us(12);
    chk("midrst_next_npix", pix_q.size() - bq, 1);
    if (pix_q.size() > bq) chk("midrst_next_pix", pix_q[bq], 32'h00123456);
    chk("midrst_fd_after", fd_cnt - bfd, 1);

    chk("inst_match", diverge, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/neopix_rx.md
# neopix_rx

WS2812 (NeoPixel) single-wire bitstream receiver: the decoding end of the `spi_to_neopix` strip output. It oversamples a data line on the 100 MHz system clock and classifies each high pulse as a 0 or 1 bit. Bits are assembled MSB-first into 24-bit GRB pixel words, and the block reports pixel index, frame end (latch gap) and framing errors. Used for loopback self-test of the strip drivers on the DE0 top and for daisy-chain monitoring.

## Interface
- `SYSTEM_CLOCK`, 100_000_000, clk_i frequency in Hz
- `NUM_LEDS`, 256, pixels accepted per frame; later pixels dropped
- `BIT_THRESHOLD_NS`, 600, high time ≥ threshold decodes as 1, else 0
- `MIN_HIGH_NS`, 100, shorter high pulse is a glitch (error)
- `RESET_US`, 50, low time ≥ this is a latch gap (frame end)
- `clk_i` in 1: system clock; one clock domain only
- `reset_i` in 1: synchronous, active-high reset
- `din_i` in 1: asynchronous NeoPixel data line
- `pixel_o` out 24: last completed word, {G,R,B}, bit 23 = first received
- `pixel_vld_o` out 1: 1-cycle strobe, `pixel_o`/`pixel_idx_o` valid
- `pixel_idx_o` out $clog2(NUM_LEDS): index of the pixel within the frame, 0-based
- `frame_done_o` out 1: 1-cycle strobe on latch gap after ≥1 bit
- `err_o` out 1: 1-cycle strobe on glitch or partial pixel at latch
- `overflow_o` out 1: sticky; more than NUM_LEDS pixels this frame; cleared on next frame's first bit
- `rx_bsy_o` out 1: high from first rising edge of a frame to its latch detection

## Operation
- Derived cycle constants (integer, truncating): THR = SYSTEM_CLOCK/1e6×BIT_THRESHOLD_NS/1000 (60), MINH (10), RST = SYSTEM_CLOCK/1e6×RESET_US (5000). The single duration counter is wide enough for RST and saturates at RST.
- `din_i` passes through a 2-flop synchronizer and then a delay flop. Rise/fall are detected from the synchronized and delayed values.
- FSM states:
  - WAIT_GAP (after reset): count low cycles; a high clears the count. Count = RST → IDLE.
  - IDLE: rise → HIGH, counter cleared.
  - HIGH: count. On fall: count < MINH → pulse `err_o`, discard the partial word, go WAIT_GAP. Otherwise shift in (count ≥ THR), bit_cnt+1, go LOW.
  - LOW: count. Rise → HIGH. Count reaches RST → LATCH.
  - LATCH (1 cycle):
    - `frame_done_o`=1.
    - If bit_cnt≠0, also `err_o`=1 and the partial word is discarded.
    - Clear pixel index and bit_cnt, then go IDLE.
- After 24 bits: `pixel_o`←word, `pixel_vld_o`=1 and `pixel_idx_o`=index, then index+1 and bit_cnt←0.
  - If index has already reached NUM_LEDS: no strobe, `overflow_o`←1, and the index holds.
- `rx_bsy_o`=1 in HIGH and LOW states.
- A high lasting past RST in HIGH is not a latch; the counter saturates and the bit decodes as 1.

## Timing
- Reset: all outputs 0, index 0, bit_cnt 0, state WAIT_GAP. Reset asserted mid-frame aborts the frame with no strobes.
- Decode latency: `pixel_vld_o` is high on the 4th rising clk_i edge after the `din_i` falling edge completing bit 23. The 4 edges are 2 sync + 1 edge flop + 1 output reg.
- `frame_done_o` asserts RST+4 cycles after the last `din_i` falling edge.
- `pixel_o` holds until the next valid word. Strobes never overlap except `frame_done_o`+`err_o` on partial-pixel latch.
- Pulse-width resolution is ±1 cycle (10 ns), due to synchronizer jitter.

## Structure
- Shared package `neopix_pkg`: WS2812 timing defaults (T0H 350 ns, T1H 700 ns, 600 ns threshold, 50 µs reset), pixel word width 24, and the ns/µs→cycle conversion function. The transmitter uses the same package.
- One sub-module, `sync_edge`: 2-flop synchronizer plus rise/fall strobes, reused for SPI inputs.

## Test plan
- 3 pixels 0xFF0000, 0x00AA55, 0x000001 (T0H 350 ns / T1H 700 ns, 1.25 µs period), then 60 µs low → 3 `pixel_vld_o` with those values at idx 0,1,2; one `frame_done_o`; `err_o`=0.
- Threshold sweep: high of 590 ns → bit 0; 610 ns → bit 1. 80 ns glitch → `err_o` pulse and FSM returns to WAIT_GAP; the next pixel is accepted only after a 50 µs gap.
- 12 bits then 60 µs low → `frame_done_o`+`err_o` same cycle, no `pixel_vld_o`; next frame's pixel 0 arrives at idx 0.
- NUM_LEDS=4, send 6 pixels → 4 strobes (idx 0-3), `overflow_o`=1 after the 5th pixel; cleared on the next frame's first bit.
- Reset after 10 bits, release, send a full pixel immediately → no strobe. After 50 µs low, a pixel 0x123456 → strobe at idx 0.
- Loopback: `spi_to_neopix` driving `din_i` with 256 random pixels → every word matches, and `frame_done_o` coincides with driver `ws_bsy_o` fall + RST.
